// File: rtl/snake_motion.sv
// Snake body engine: advances a circular coordinate buffer once per game step,
// detects wall/self collisions, grows on food and exposes a segment read port.
module snake_motion #(
    parameter  int GRID_W      = 32,
    parameter  int GRID_H      = 24,
    parameter  int MAX_LEN     = 16,
    parameter  int TICK_CYCLES = 2500000,
    localparam int XW          = $clog2(GRID_W),
    localparam int YW          = $clog2(GRID_H),
    localparam int LW          = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    dir,
    input  logic          start,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [LW-1:0] length,
    output logic          alive,
    output logic          step,
    output logic          ate,
    input  logic [LW-1:0] seg_idx,
    output logic [XW-1:0] seg_x,
    output logic [YW-1:0] seg_y,
    output logic          seg_valid
);

    localparam int PW = $clog2(MAX_LEN);
    localparam int CW = $clog2(TICK_CYCLES);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt;
    logic [PW-1:0] head_ptr;
    logic [LW-1:0] len_q;
    logic [1:0]    heading;
    logic [XW-1:0] hx;
    logic [YW-1:0] hy;
    logic          step_q, ate_q;

    logic [XW-1:0] buf_x [MAX_LEN];
    logic [YW-1:0] buf_y [MAX_LEN];

    logic          tick, reversal, wall, eat, grow, self_hit;
    logic          reinit, do_move;
    logic [1:0]    new_head;
    logic [XW-1:0] cand_x;
    logic [YW-1:0] cand_y;
    logic [PW-1:0] ptr_dec, rd_ptr;

    logic          wr_en;
    logic [PW-1:0] wr_ptr;
    logic [XW-1:0] wr_x;
    logic [YW-1:0] wr_y;

    // Offset from the head pointer, wrapped into the circular buffer.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [LW-1:0] o);
        logic [LW:0] s;
        s = (LW+1)'(p) + (LW+1)'(o);
        if (s >= (LW+1)'(MAX_LEN))
            s = s - (LW+1)'(MAX_LEN);
        return s[PW-1:0];
    endfunction

    assign tick     = (state_q == RUN) && (cnt == CW'(TICK_CYCLES - 1));
    assign reversal = (dir[1] == heading[1]) && (dir[0] != heading[0]) && (len_q > LW'(1));
    assign new_head = reversal ? heading : dir;
    assign ptr_dec  = (head_ptr == '0) ? PW'(MAX_LEN - 1) : head_ptr - PW'(1);

    // Boundary test first so the +-1 never wraps.
    always_comb begin
        cand_x = hx;
        cand_y = hy;
        wall   = 1'b0;
        case (new_head)
            2'b00: if (hy == '0) wall = 1'b1; else cand_y = hy - YW'(1);
            2'b01: if (hy == YW'(GRID_H - 1)) wall = 1'b1; else cand_y = hy + YW'(1);
            2'b10: if (hx == '0) wall = 1'b1; else cand_x = hx - XW'(1);
            default: if (hx == XW'(GRID_W - 1)) wall = 1'b1; else cand_x = hx + XW'(1);
        endcase
    end

    assign eat  = (cand_x == food_x) && (cand_y == food_y);
    assign grow = eat && (len_q < LW'(MAX_LEN));

    // The tail only counts as an obstacle when it stays put (growing move).
    always_comb begin
        self_hit = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LW'(i) < len_q - LW'(1)) || ((LW'(i) == len_q - LW'(1)) && grow)) begin
                if (buf_x[ptr_add(head_ptr, LW'(i))] == cand_x &&
                    buf_y[ptr_add(head_ptr, LW'(i))] == cand_y)
                    self_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        reinit  = 1'b0;
        do_move = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                reinit  = 1'b1;
            end
            RUN: if (tick) begin
                if (wall || self_hit) state_d = DEAD;
                else                  do_move = 1'b1;
            end
            DEAD: if (start) begin
                state_d = RUN;
                reinit  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt      <= '0;
            head_ptr <= '0;
            len_q    <= LW'(1);
            heading  <= 2'b11;
            hx       <= XW'(GRID_W / 2);
            hy       <= YW'(GRID_H / 2);
            step_q   <= 1'b0;
            ate_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= do_move;
            ate_q   <= do_move && eat;
            if (reinit) begin
                cnt      <= '0;
                head_ptr <= '0;
                len_q    <= LW'(1);
                heading  <= 2'b11;
                hx       <= XW'(GRID_W / 2);
                hy       <= YW'(GRID_H / 2);
            end else if (state_q == RUN) begin
                cnt <= tick ? '0 : cnt + CW'(1);
                if (tick)
                    heading <= new_head;
                if (do_move) begin
                    head_ptr <= ptr_dec;
                    hx       <= cand_x;
                    hy       <= cand_y;
                    if (grow)
                        len_q <= len_q + LW'(1);
                end
            end
        end
    end

    // Reset and restart seed slot 0 with the start cell; moves write the new head.
    always_comb begin
        wr_en  = !rst_n || reinit || do_move;
        wr_ptr = ptr_dec;
        wr_x   = cand_x;
        wr_y   = cand_y;
        if (!rst_n || reinit) begin
            wr_ptr = '0;
            wr_x   = XW'(GRID_W / 2);
            wr_y   = YW'(GRID_H / 2);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_x[wr_ptr] <= wr_x;
            buf_y[wr_ptr] <= wr_y;
        end
    end

    assign rd_ptr    = ptr_add(head_ptr, seg_idx);
    assign seg_valid = seg_idx < len_q;
    assign seg_x     = seg_valid ? buf_x[rd_ptr] : '0;
    assign seg_y     = seg_valid ? buf_y[rd_ptr] : '0;

    assign head_x = hx;
    assign head_y = hy;
    assign length = len_q;
    assign alive  = (state_q == RUN);
    assign step   = step_q;
    assign ate    = ate_q;

endmodule

// File: tb/tb_snake_motion.sv
// Bench for snake_motion: directed table, hand sequences and random play
// checked against a queue-based model of the snake.
module tb_snake_motion;
    localparam int GW = 32, GH = 24, ML = 16, T = 4;
    localparam int XW = 5, YW = 5, LW = 5;

    logic          clk = 1'b0;
    logic          rst_n, start;
    logic [1:0]    dir;
    logic [XW-1:0] food_x, head_x, seg_x;
    logic [YW-1:0] food_y, head_y, seg_y;
    logic [LW-1:0] length, seg_idx;
    logic          alive, step, ate, seg_valid;

    always #5 clk = ~clk;

    snake_motion #(.GRID_W(GW), .GRID_H(GH), .MAX_LEN(ML), .TICK_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .dir(dir), .start(start),
        .food_x(food_x), .food_y(food_y),
        .head_x(head_x), .head_y(head_y), .length(length),
        .alive(alive), .step(step), .ate(ate),
        .seg_idx(seg_idx), .seg_x(seg_x), .seg_y(seg_y), .seg_valid(seg_valid)
    );

    typedef struct {int x; int y;} pt_t;
    pt_t body[$];
    int  m_state, m_cnt, m_head;
    bit  e_step, e_ate;
    int  total = 0, bad = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void m_init();
        body.delete();
        body.push_back('{GW / 2, GH / 2});
        m_head = 3;
        m_cnt  = 0;
    endfunction

    function automatic bit opposite(input int a, input int b);
        return (a == 0 && b == 1) || (a == 1 && b == 0) || (a == 2 && b == 3) || (a == 3 && b == 2);
    endfunction

    function automatic void m_move();
        int d, cx, cy;
        bit hit, eat, grow;
        d = int'(dir);
        if (opposite(d, m_head) && body.size() > 1) d = m_head;
        m_head = d;
        cx = body[0].x;
        cy = body[0].y;
        case (d)
            0: cy = cy - 1;
            1: cy = cy + 1;
            2: cx = cx - 1;
            default: cx = cx + 1;
        endcase
        if (cx < 0 || cx >= GW || cy < 0 || cy >= GH) begin
            m_state = 2;
            return;
        end
        eat  = (cx == int'(food_x)) && (cy == int'(food_y));
        grow = eat && body.size() < ML;
        hit  = 0;
        for (int i = 0; i < body.size(); i++)
            if (!(i == body.size() - 1 && !grow) && body[i].x == cx && body[i].y == cy) hit = 1;
        if (hit) begin
            m_state = 2;
            return;
        end
        body.push_front('{cx, cy});
        if (!grow) void'(body.pop_back());
        e_step = 1;
        e_ate  = eat;
    endfunction

    function automatic void model_update();
        e_step = 0;
        e_ate  = 0;
        if (!rst_n) begin
            m_state = 0;
            m_init();
        end else begin
            case (m_state)
                1: if (m_cnt == T - 1) begin
                    m_cnt = 0;
                    m_move();
                end else m_cnt++;
                default: if (start) begin
                    m_state = 1;
                    m_init();
                end
            endcase
        end
    endfunction

    task automatic tick();
        int idx;
        @(posedge clk);
        model_update();
        @(negedge clk);
        check("head_x", int'(head_x), body[0].x);
        check("head_y", int'(head_y), body[0].y);
        check("length", int'(length), body.size());
        check("alive", int'(alive), int'(m_state == 1));
        check("step", int'(step), int'(e_step));
        check("ate", int'(ate), int'(e_ate));
        idx = int'($urandom_range(0, ML + 1));
        seg_idx = LW'(idx);
        #1;
        check("seg_valid", int'(seg_valid), int'(idx < body.size()));
        check("seg_x", int'(seg_x), idx < body.size() ? body[idx].x : 0);
        check("seg_y", int'(seg_y), idx < body.size() ? body[idx].y : 0);
    endtask

    task automatic seg_check(input int idx, input int ex, input int ey, input int ev);
        seg_idx = LW'(idx);
        #1;
        check("tbl_seg_x", int'(seg_x), ex);
        check("tbl_seg_y", int'(seg_y), ey);
        check("tbl_seg_valid", int'(seg_valid), ev);
    endtask

    typedef struct {
        bit st; bit [1:0] d; int fx; int fy; int cyc;
        int hx; int hy; int len; bit alv; bit stp; bit at;
        int sidx; int sx; int sy; bit sv;
    } vec_t;
    vec_t tbl[22];

    initial begin
        tbl[0]  = '{1, 3, 31, 23,  1, 16, 12, 1, 1, 0, 0, 1,  0,  0, 0};
        tbl[1]  = '{0, 3, 31, 23,  4, 17, 12, 1, 1, 1, 0, 0, 17, 12, 1};
        tbl[2]  = '{0, 3, 31, 23,  4, 18, 12, 1, 1, 1, 0, 0, 18, 12, 1};
        tbl[3]  = '{0, 3, 31, 23,  4, 19, 12, 1, 1, 1, 0, 0, 19, 12, 1};
        tbl[4]  = '{0, 3, 20, 12,  4, 20, 12, 2, 1, 1, 1, 1, 19, 12, 1};
        tbl[5]  = '{0, 2, 31, 23,  4, 21, 12, 2, 1, 1, 0, 1, 20, 12, 1};
        tbl[6]  = '{0, 3, 22, 12,  4, 22, 12, 3, 1, 1, 1, 2, 20, 12, 1};
        tbl[7]  = '{0, 3, 23, 12,  4, 23, 12, 4, 1, 1, 1, 0, 23, 12, 1};
        tbl[8]  = '{0, 3, 24, 12,  4, 24, 12, 5, 1, 1, 1, 4, 20, 12, 1};
        tbl[9]  = '{0, 1, 31, 23,  4, 24, 13, 5, 1, 1, 0, 1, 24, 12, 1};
        tbl[10] = '{0, 2, 31, 23,  4, 23, 13, 5, 1, 1, 0, 2, 24, 12, 1};
        tbl[11] = '{0, 0, 31, 23,  4, 23, 13, 5, 0, 0, 0, 4, 22, 12, 1};
        tbl[12] = '{0, 0, 31, 23,  8, 23, 13, 5, 0, 0, 0, 5,  0,  0, 0};
        tbl[13] = '{1, 3, 31, 23,  1, 16, 12, 1, 1, 0, 0, 0, 16, 12, 1};
        tbl[14] = '{0, 3, 17, 12,  4, 17, 12, 2, 1, 1, 1, 1, 16, 12, 1};
        tbl[15] = '{0, 3, 18, 12,  4, 18, 12, 3, 1, 1, 1, 2, 16, 12, 1};
        tbl[16] = '{0, 3, 19, 12,  4, 19, 12, 4, 1, 1, 1, 3, 16, 12, 1};
        tbl[17] = '{0, 1, 31, 23,  4, 19, 13, 4, 1, 1, 0, 3, 17, 12, 1};
        tbl[18] = '{0, 2, 31, 23,  4, 18, 13, 4, 1, 1, 0, 3, 18, 12, 1};
        tbl[19] = '{0, 0, 31, 23,  4, 18, 12, 4, 1, 1, 0, 3, 19, 12, 1};
        tbl[20] = '{0, 0, 31, 23, 48, 18,  0, 4, 1, 1, 0, 3, 18,  3, 1};
        tbl[21] = '{0, 0, 31, 23,  4, 18,  0, 4, 0, 0, 0, 0, 18,  0, 1};

        rst_n = 1'b0; start = 1'b0; dir = 2'b11;
        food_x = 5'd31; food_y = 5'd23; seg_idx = '0;
        m_state = 0; m_init(); e_step = 0; e_ate = 0;

        // Reset, then a long idle stretch with start low.
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("idle_head_x", int'(head_x), 16);
        check("idle_head_y", int'(head_y), 12);
        check("idle_length", int'(length), 1);
        check("idle_alive", int'(alive), 0);
        check("idle_step", int'(step), 0);

        for (int i = 0; i < 22; i++) begin
            start  = tbl[i].st;
            dir    = tbl[i].d;
            food_x = XW'(tbl[i].fx);
            food_y = YW'(tbl[i].fy);
            repeat (tbl[i].cyc) tick();
            check("tbl_head_x", int'(head_x), tbl[i].hx);
            check("tbl_head_y", int'(head_y), tbl[i].hy);
            check("tbl_length", int'(length), tbl[i].len);
            check("tbl_alive", int'(alive), int'(tbl[i].alv));
            check("tbl_step", int'(step), int'(tbl[i].stp));
            check("tbl_ate", int'(ate), int'(tbl[i].at));
            seg_check(tbl[i].sidx, tbl[i].sx, tbl[i].sy, int'(tbl[i].sv));
        end

        // Grow to the length cap, eat once more at the cap, then hit the right wall.
        start = 1'b1; tick(); start = 1'b0;
        dir = 2'b11;
        for (int k = 1; k <= 15; k++) begin
            food_x = XW'(16 + k); food_y = 5'd12;
            repeat (T) tick();
            check("grow_len", int'(length), k + 1);
        end
        dir = 2'b01; food_x = 5'd31; food_y = 5'd13;
        repeat (T) tick();
        check("cap_ate", int'(ate), 1);
        check("cap_len", int'(length), 16);
        check("cap_head_y", int'(head_y), 13);
        seg_check(15, 17, 12, 1);
        dir = 2'b11; food_x = 5'd0; food_y = 5'd0;
        repeat (T) tick();
        check("rwall_alive", int'(alive), 0);
        check("rwall_head_x", int'(head_x), 31);

        // Reset landing exactly on a move edge.
        start = 1'b1; tick(); start = 1'b0;
        repeat (T - 1) tick();
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("mreset_head_x", int'(head_x), 16);
        check("mreset_head_y", int'(head_y), 12);
        check("mreset_length", int'(length), 1);
        check("mreset_alive", int'(alive), 0);
        check("mreset_step", int'(step), 0);

        // Random play; food is often dropped next to the head to provoke growth.
        start = 1'b1; tick();
        for (int n = 0; n < 1500; n++) begin
            dir   = 2'($urandom_range(0, 3));
            start = ($urandom_range(0, 99) == 0);
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 1) == 1) begin
                food_x = XW'(body[0].x + int'($urandom_range(0, 2)) - 1);
                food_y = YW'(body[0].y + int'($urandom_range(0, 2)) - 1);
            end
            tick();
        end
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
